// File: rtl/fpu_pkg.sv
// Shared floating-point types: rounding modes, exception flag bundle and the
// canonical quiet-NaN builder used by the FP datapath blocks.
package fpu_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rnd_mode_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Canonical qNaN {0, all-ones exponent, 1, 0...} right-aligned in 64 bits;
    // callers slice off the low 1+exp_w+man_w bits.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w+i] = 1'b1;
        end
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Combinational normalise/round/pack of a raw significand product into an
// IEEE-style word with overflow/underflow saturation per rounding mode.
module fpu_round_pack
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W,
    localparam int P    = 2 * MAN_W + 2
) (
    input  logic                    sign_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  logic [P-1:0]            prod_i,
    input  rnd_mode_e               rnd_i,
    output logic [W-1:0]            res_o,
    output fp_flags_t               flags_o
);

    localparam logic signed [EXP_W+1:0] EXP_SAT = (EXP_W+2)'(2**EXP_W - 1);

    logic [P-1:0]            norm;
    logic signed [EXP_W+1:0] exp_n;
    logic signed [EXP_W+1:0] exp_r;
    logic [MAN_W+1:0]        mant_r;
    logic                    lsb, g, r, s, inexact, round_up;
    logic [W-1:0]            inf_res, max_res;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4): at most one shift.
        norm  = prod_i[P-1] ? prod_i : {prod_i[P-2:0], 1'b0};
        exp_n = exp_i + {{(EXP_W+1){1'b0}}, prod_i[P-1]};

        lsb     = norm[P-1-MAN_W];
        g       = norm[P-2-MAN_W];
        r       = norm[P-3-MAN_W];
        s       = |norm[P-4-MAN_W:0];
        inexact = g | r | s;

        case (rnd_i)
            RNE:     round_up = g & (r | s | lsb);
            RTZ:     round_up = 1'b0;
            RUP:     round_up = !sign_i & inexact;
            RDN:     round_up = sign_i & inexact;
            default: round_up = 1'b0;
        endcase

        // A carry out of the hidden bit leaves an all-zero fraction; only the
        // exponent needs to absorb it.
        mant_r = {1'b0, norm[P-1 -: MAN_W+1]} + {{(MAN_W+1){1'b0}}, round_up};
        exp_r  = exp_n + {{(EXP_W+1){1'b0}}, mant_r[MAN_W+1]};

        inf_res = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        max_res = {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

        flags_o = '0;
        if (exp_r >= EXP_SAT) begin
            flags_o.overflow = 1'b1;
            flags_o.inexact  = 1'b1;
            case (rnd_i)
                RNE:     res_o = inf_res;
                RTZ:     res_o = max_res;
                RUP:     res_o = sign_i ? max_res : inf_res;
                RDN:     res_o = sign_i ? inf_res : max_res;
                default: res_o = inf_res;
            endcase
        end else if (exp_r[EXP_W+1] || exp_r == '0) begin
            flags_o.underflow = 1'b1;
            flags_o.inexact   = 1'b1;
            res_o             = {sign_i, {(W-1){1'b0}}};
        end else begin
            flags_o.inexact = inexact;
            res_o           = {sign_i, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fpu_mult_pipe.sv
// Two-stage valid/ready floating-point multiplier: stage 1 unpacks, classifies
// and multiplies significands; stage 2 rounds/packs and tracks sticky flags.
module fpu_mult_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     i_op_a,
    input  logic [W-1:0]     i_op_b,
    input  logic [1:0]       i_rnd,
    input  logic [TAG_W-1:0] i_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic [3:0]       o_flags,
    input  logic             flags_clr,
    output logic [3:0]       o_sticky
);

    localparam int P = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic [63:0]  QNAN64 = qnan_bits(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN   = QNAN64[W-1:0];

    logic en1, en2, xfer_out;

    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        ma, mb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                    sign_d, spec_d;
    logic [W-1:0]            spec_res_d;
    fp_flags_t               spec_flags_d;
    logic signed [EXP_W+1:0] exp_d;
    logic [P-1:0]            prod_d;

    logic                    s1_valid_q, sign_q, spec_q;
    logic signed [EXP_W+1:0] exp_q;
    logic [P-1:0]            prod_q;
    rnd_mode_e               rnd_q;
    logic [TAG_W-1:0]        tag_q;
    logic [W-1:0]            spec_res_q;
    fp_flags_t               spec_flags_q;

    logic [W-1:0]            rp_res, res_d;
    fp_flags_t               rp_flags, flags_d;

    logic                    out_valid_q;
    logic [W-1:0]            res_q;
    logic [TAG_W-1:0]        otag_q;
    logic [3:0]              flags_q, sticky_q;

    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;
    assign xfer_out = out_valid_q && out_ready;

    always_comb begin
        ea = i_op_a[W-2:MAN_W];
        eb = i_op_b[W-2:MAN_W];
        ma = i_op_a[MAN_W-1:0];
        mb = i_op_b[MAN_W-1:0];

        // Subnormals (exp == 0) count as zero regardless of fraction.
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (ma == '0);
        b_inf  = (&eb) && (mb == '0);
        a_nan  = (&ea) && (ma != '0);
        b_nan  = (&eb) && (mb != '0);

        sign_d = i_op_a[W-1] ^ i_op_b[W-1];
        exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
        prod_d = (P)'({1'b1, ma}) * (P)'({1'b1, mb});

        spec_d       = 1'b1;
        spec_flags_d = '0;
        spec_res_d   = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res_d           = QNAN;
            spec_flags_d.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_res_d = {sign_d, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            prod_q       <= '0;
            rnd_q        <= RNE;
            tag_q        <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
        end else if (en1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                sign_q       <= sign_d;
                exp_q        <= exp_d;
                prod_q       <= prod_d;
                rnd_q        <= rnd_mode_e'(i_rnd);
                tag_q        <= i_tag;
                spec_q       <= spec_d;
                spec_res_q   <= spec_res_d;
                spec_flags_q <= spec_flags_d;
            end
        end
    end

    fpu_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign_i  (sign_q),
        .exp_i   (exp_q),
        .prod_i  (prod_q),
        .rnd_i   (rnd_q),
        .res_o   (rp_res),
        .flags_o (rp_flags)
    );

    assign res_d   = spec_q ? spec_res_q : rp_res;
    assign flags_d = spec_q ? spec_flags_q : rp_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            otag_q      <= '0;
            flags_q     <= '0;
            sticky_q    <= '0;
        end else begin
            if (en2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q   <= res_d;
                    otag_q  <= tag_q;
                    flags_q <= flags_d;
                end
            end
            // Clear wins, but a result leaving this cycle still lands in the sticky set.
            if (flags_clr) begin
                sticky_q <= xfer_out ? flags_q : 4'b0000;
            end else if (xfer_out) begin
                sticky_q <= sticky_q | flags_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign o_res     = res_q;
    assign o_tag     = otag_q;
    assign o_flags   = flags_q;
    assign o_sticky  = sticky_q;

endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Directed bench for fpu_mult_pipe (FP32): rounding, specials, overflow,
// underflow, stalled streaming, sticky flags and asynchronous reset.
module tb_fpu_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] i_op_a = '0;
    logic [31:0] i_op_b = '0;
    logic [1:0]  i_rnd = 2'd0;
    logic [3:0]  i_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] o_res;
    logic [3:0]  o_tag;
    logic [3:0]  o_flags;
    logic        flags_clr = 1'b0;
    logic [3:0]  o_sticky;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_op_a    (i_op_a),
        .i_op_b    (i_op_b),
        .i_rnd     (i_rnd),
        .i_tag     (i_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_res     (o_res),
        .o_tag     (o_tag),
        .o_flags   (o_flags),
        .flags_clr (flags_clr),
        .o_sticky  (o_sticky)
    );

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp_v);
        end
    endtask

    // One operation through an idle pipe with out_ready high; called at a negedge.
    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rnd, input logic [3:0] tag,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags,
                         input logic clr);
        i_op_a   = a;
        i_op_b   = b;
        i_rnd    = rnd;
        i_tag    = tag;
        in_valid = 1'b1;
        #1;
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({nm, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_lat2"}, 32'(out_valid), 32'd1);
        check({nm, "_res"}, o_res, exp_res);
        check({nm, "_flags"}, 32'(o_flags), 32'(exp_flags));
        check({nm, "_tag"}, 32'(o_tag), 32'(tag));
        $display("op %s: %h x %h rnd=%0d -> %h flags=%b tag=%0d", nm, a, b, rnd, o_res, o_flags, o_tag);
        flags_clr = clr;
        @(negedge clk);
        flags_clr = 1'b0;
        check({nm, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] rdy_pat = 16'b1011_0010_1110_0101;
    logic        m_s1, m_out, m_en1, m_en2, hold;
    logic [31:0] prev_res;
    logic [3:0]  prev_tag;
    int          sent, got;

    initial begin
        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", o_res, 32'h0);
        check("rst_tag", 32'(o_tag), 32'd0);
        check("rst_flags", 32'(o_flags), 32'd0);
        check("rst_sticky", 32'(o_sticky), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul6",     32'h40400000, 32'h40000000, 2'd0, 4'd5, 32'h40C00000, 4'b0000, 1'b0);
        do_op("inx_rne",  32'h3F800001, 32'h3F800001, 2'd0, 4'd1, 32'h3F800002, 4'b0001, 1'b0);
        do_op("inx_rup",  32'h3F800001, 32'h3F800001, 2'd2, 4'd2, 32'h3F800003, 4'b0001, 1'b0);
        do_op("inx_rtz",  32'h3F800001, 32'h3F800001, 2'd1, 4'd3, 32'h3F800002, 4'b0001, 1'b0);
        do_op("inx_rdn",  32'h3F800001, 32'h3F800001, 2'd3, 4'd4, 32'h3F800002, 4'b0001, 1'b0);
        do_op("neg_rdn",  32'hBF800001, 32'h3F800001, 2'd3, 4'd6, 32'hBF800003, 4'b0001, 1'b0);
        do_op("ovf_rne",  32'h7F000000, 32'h7F000000, 2'd0, 4'd7, 32'h7F800000, 4'b0101, 1'b0);
        do_op("ovf_rtz",  32'h7F000000, 32'h7F000000, 2'd1, 4'd8, 32'h7F7FFFFF, 4'b0101, 1'b0);
        do_op("ovf_rdn",  32'h7F000000, 32'h7F000000, 2'd3, 4'd9, 32'h7F7FFFFF, 4'b0101, 1'b0);
        do_op("novf_rup", 32'hFF000000, 32'h7F000000, 2'd2, 4'd10, 32'hFF7FFFFF, 4'b0101, 1'b0);
        do_op("inf_zero", 32'h7F800000, 32'h00000000, 2'd0, 4'd11, 32'h7FC00000, 4'b1000, 1'b0);
        do_op("snan",     32'h7FA00000, 32'h3F800000, 2'd0, 4'd12, 32'h7FC00000, 4'b1000, 1'b0);
        do_op("ninf_x",   32'hFF800000, 32'h40000000, 2'd0, 4'd13, 32'hFF800000, 4'b0000, 1'b0);
        do_op("undf",     32'h00800000, 32'h3F000000, 2'd0, 4'd14, 32'h00000000, 4'b0011, 1'b0);
        do_op("subn",     32'h00000001, 32'h40000000, 2'd0, 4'd15, 32'h00000000, 4'b0000, 1'b0);
        check("sticky_accum", 32'(o_sticky), 32'b1111);

        // Sticky accumulation and clear
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        check("sticky_clr", 32'(o_sticky), 32'd0);
        do_op("stk_ovf",  32'h7F000000, 32'h7F000000, 2'd0, 4'd1, 32'h7F800000, 4'b0101, 1'b0);
        do_op("stk_clean", 32'h40400000, 32'h40000000, 2'd0, 4'd2, 32'h40C00000, 4'b0000, 1'b0);
        check("sticky_ovf", 32'(o_sticky), 32'b0101);
        do_op("stk_clrx", 32'h3F800001, 32'h3F800001, 2'd0, 4'd3, 32'h3F800002, 4'b0001, 1'b1);
        check("sticky_clr_xfer", 32'(o_sticky), 32'b0001);

        // Stream of 8 ops (2^i x 3.0 = 3*2^i) with out_ready from a fixed pattern
        sent = 0;
        got  = 0;
        m_s1 = 1'b0;
        m_out = 1'b0;
        hold = 1'b0;
        prev_res = '0;
        prev_tag = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            out_ready = rdy_pat[cyc % 16];
            in_valid  = (sent < 8);
            i_op_a    = 32'h3F800000 + (32'(sent) << 23);
            i_op_b    = 32'h40400000;
            i_rnd     = 2'd0;
            i_tag     = 4'(sent);
            #1;
            m_en2 = !m_out || out_ready;
            m_en1 = !m_s1 || m_en2;
            check("strm_out_valid", 32'(out_valid), 32'(m_out));
            check("strm_in_ready", 32'(in_ready), 32'(m_en1));
            if (hold) begin
                check("strm_hold_res", o_res, prev_res);
                check("strm_hold_tag", 32'(o_tag), 32'(prev_tag));
            end
            if (out_valid && out_ready) begin
                check("strm_res", o_res, 32'h40400000 + (32'(got) << 23));
                check("strm_tag", 32'(o_tag), 32'(got));
                $display("stream result %0d: %h tag=%0d", got, o_res, o_tag);
                got++;
            end
            if (in_valid && in_ready) sent++;
            if (m_en2) m_out = m_s1;
            if (m_en1) m_s1 = in_valid;
            hold     = out_valid && !out_ready;
            prev_res = o_res;
            prev_tag = o_tag;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("strm_count", 32'(got), 32'd8);
        @(negedge clk);
        @(negedge clk);
        check("strm_no_extra", 32'(out_valid), 32'd0);

        // Asynchronous reset with the pipeline full and stalled
        out_ready = 1'b0;
        i_op_a    = 32'h40400000;
        i_op_b    = 32'h40000000;
        in_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_res", o_res, 32'h0);
        check("arst_sticky", 32'(o_sticky), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("arst_discard", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
